// File: rtl/upsample_frame_sequencer.sv
// Frame-level scheduler for the 2x bilinear upsampler: walks the 2*IMG_H output
// rows and issues one line job per row (source bases, vertical select, dest base).
module upsample_frame_sequencer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              line_done,
  output logic              line_start,
  output logic [ADDR_W-1:0] src_a_base,
  output logic [ADDR_W-1:0] src_b_base,
  output logic              vsel,
  output logic [ADDR_W-1:0] dst_base,
  output logic [9:0]        out_row,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // Handshake: line_start is a one-cycle launch pulse; the job's addresses are
  // held until line_done (one-cycle pulse, accepted only in WAIT_LINE) is seen.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LINE = 3'd2,
    NEXT      = 3'd3,
    FIN       = 3'd4
  } state_t;

  localparam logic [9:0]        LAST_ROW = 10'(2 * IMG_H - 1);
  localparam logic [8:0]        LAST_SRC = 9'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] DST_STEP = ADDR_W'(2 * IMG_W);

  state_t            state_q, state_d;
  logic [9:0]        k_q, k_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              err_q, err_d;
  logic              line_start_q, line_start_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [9:0]        k_inc;
  logic [ADDR_W-1:0] a_next;

  assign k_inc  = k_q + 10'd1;
  assign a_next = a_base_q + ROW_STEP;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    dst_d    = dst_q;
    err_d    = err_q;

    if (line_done && (state_q != WAIT_LINE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          err_d   = 1'b0;
        end
      end
      ISSUE: state_d = WAIT_LINE;
      WAIT_LINE: begin
        if (line_done) state_d = NEXT;
      end
      NEXT: begin
        if (k_q == LAST_ROW) begin
          state_d = FIN;
        end else begin
          state_d = ISSUE;
          k_d     = k_inc;
          dst_d   = dst_q + DST_STEP;
          if (!k_inc[0]) begin
            // Even rows are straight copies: both sources step to the new row.
            a_base_d = a_next;
            b_base_d = a_next;
          end else if (k_q[9:1] < LAST_SRC) begin
            b_base_d = a_next;
          end else begin
            // Bottom edge: the lower neighbour is clamped to the last row.
            b_base_d = a_base_q;
          end
        end
      end
      FIN: begin
        state_d  = IDLE;
        k_d      = '0;
        a_base_d = '0;
        b_base_d = '0;
        dst_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      k_d      = '0;
      a_base_d = '0;
      b_base_d = '0;
      dst_d    = '0;
      err_d    = err_q;
    end
  end

  always_comb begin
    line_start_d = (state_d == ISSUE);
    done_d       = (state_d == FIN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      dst_q        <= '0;
      err_q        <= 1'b0;
      line_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_base_q     <= a_base_d;
      b_base_q     <= b_base_d;
      dst_q        <= dst_d;
      err_q        <= err_d;
      line_start_q <= line_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign line_start = line_start_q;
  assign src_a_base = a_base_q;
  assign src_b_base = b_base_q;
  assign vsel       = k_q[0];
  assign dst_base   = dst_q;
  assign out_row    = k_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_upsample_frame_sequencer.sv
// Bench for upsample_frame_sequencer: random line-controller latencies, directed
// abort/reset/error cases, scoreboard of expected jobs checked by a monitor.
module tb_upsample_frame_sequencer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 19;
  localparam int ROWS   = 2 * IMG_H;
  localparam int EW     = 1 + 10 + 3 * ADDR_W + 1;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              line_done = 1'b0;
  logic              line_start;
  logic [ADDR_W-1:0] src_a_base;
  logic [ADDR_W-1:0] src_b_base;
  logic              vsel;
  logic [ADDR_W-1:0] dst_base;
  logic [9:0]        out_row;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  upsample_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .line_done(line_done),
    .line_start(line_start), .src_a_base(src_a_base), .src_b_base(src_b_base),
    .vsel(vsel), .dst_base(dst_base), .out_row(out_row), .busy(busy),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] job_word(input int k, input bit is_done);
    int a;
    int b;
    a = k / 2;
    b = a + (k % 2);
    if (b > IMG_H - 1) b = IMG_H - 1;
    return {is_done, 10'(k), ADDR_W'(a * IMG_W), ADDR_W'(b * IMG_W),
            ((k % 2) == 1), ADDR_W'(k * 2 * IMG_W)};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (line_start === 1'b1 || done === 1'b1) begin
      logic [EW-1:0] got;
      got = {done, out_row, src_a_base, src_b_base, vsel, dst_base};
      if (exp_q.size() == 0) begin
        check("unexpected_event", got, '0);
      end else begin
        check("event_fields", got, exp_q.pop_front());
      end
      if (exp_cyc_q.size() == 0) begin
        check("unexpected_event_time", 128'(cyc), 128'(-1));
      end else begin
        check("event_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_line_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (line_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input int n_jobs, input bit with_done);
    for (int k = 0; k < n_jobs; k++) exp_q.push_back(job_word(k, 1'b0));
    if (with_done) exp_q.push_back(job_word(ROWS - 1, 1'b1));
    exp_cyc_q.push_back(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared_by_start", err, 1'b0);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic serve_job(input int k, input int lat);
    bit ok;
    wait_line_start(ok);
    check("line_start_seen", ok, 1'b1);
    if (!ok) return;
    repeat (lat + 1) @(negedge clk);
    check("addr_hold", {1'b0, out_row, src_a_base, src_b_base, vsel, dst_base}, job_word(k, 1'b0));
    line_done = 1'b1;
    start = ($urandom_range(0, 3) == 0);
    exp_cyc_q.push_back(cyc + 2);
    @(negedge clk);
    line_done = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_frame(input int lat);
    bit seen;
    start_frame(ROWS, 1'b1);
    for (int k = 0; k < ROWS; k++) serve_job(k, (lat < 0) ? $urandom_range(0, 6) : lat);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
    check("busy_at_done", busy, 1'b1);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("idle_row_zero", {out_row, dst_base}, '0);
    check("frame_err", err, 1'b0);
    check("frame_queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {line_start, busy, done, err, vsel, out_row, src_a_base, src_b_base,
                 dst_base, state_dbg}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    repeat (2) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      line_done = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check_all_zero("reset_outputs");
    start = 1'b0;
    abort = 1'b0;
    line_done = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_no_activity", {busy, line_start}, 2'b00);
    end

    // Frame with 5-cycle line latency, then minimum latency, then random.
    run_frame(4);
    repeat (3) @(negedge clk);
    run_frame(0);
    repeat (3) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      run_frame(-1);
    end

    // Abort during WAIT_LINE of k=3, together with line_done.
    start_frame(4, 1'b0);
    for (int k = 0; k < 3; k++) serve_job(k, $urandom_range(0, 3));
    wait_line_start(ok);
    check("abort_line_start_seen", ok, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    line_done = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    line_done = 1'b0;
    check("abort_state", {busy, state_dbg, out_row, dst_base}, '0);
    check("abort_no_err", err, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_queue_empty", 128'(exp_q.size()), 128'(0));
    run_frame(-1);

    // start and abort together in IDLE: stay idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", {busy, state_dbg}, {1'b0, ST_IDLE});
    repeat (3) @(negedge clk);

    // Spurious line_done in IDLE sets err; the next start clears it.
    line_done = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
    check("spurious_err", err, 1'b1);
    check("spurious_state", {busy, state_dbg}, {1'b0, ST_IDLE});
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1'b1);
    run_frame(-1);

    // Reset asserted while job k=4 is in flight.
    start_frame(5, 1'b0);
    for (int k = 0; k < 4; k++) serve_job(k, $urandom_range(0, 3));
    wait_line_start(ok);
    check("reset_line_start_seen", ok, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_all_zero("midframe_reset");
    check("reset_queue_empty", 128'(exp_q.size()), 128'(0));
    repeat (2) @(negedge clk);
    run_frame(-1);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 128'(exp_q.size() + exp_cyc_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
